// File: rtl/i2c_cmd_master.sv
// Single-master I2C command writer: START, {SLAVE_ADDR,W}, opcode, optional argument, STOP.
// SCL is built from CLK_DIV-cycle quarters; slave clock stretching is honoured in the SCL high phase.
module i2c_cmd_master #(
  parameter int unsigned CLK_DIV    = 120,
  parameter logic [6:0]  SLAVE_ADDR = 7'h41
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic [7:0] cmd_arg,
  input  logic       cmd_has_arg,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, BUS_WAIT, START, ADDR, ACK_A, DATA0, ACK0, DATA1, ACK1, STOP
  } state_t;

  state_t        state, next;
  logic [CW-1:0] qcnt;
  logic [1:0]    q;
  logic [2:0]    bit_cnt;
  logic [7:0]    cmd_q, arg_q;
  logic          has_arg_q;
  logic          nack_flag;
  logic          sda_drive;
  logic          is_byte, is_ack, stall, tick, last_q, handshake, finishing;
  logic [7:0]    cur_byte;

  assign handshake = cmd_valid && cmd_ready;
  assign is_byte   = (state == ADDR) || (state == DATA0) || (state == DATA1);
  assign is_ack    = (state == ACK_A) || (state == ACK0) || (state == ACK1);
  assign stall     = (is_byte || is_ack) && ((q == 2'd1) || (q == 2'd2)) && !scl_in;
  assign tick      = (state != IDLE) && (state != BUS_WAIT) && !stall
                     && (qcnt == CW'(CLK_DIV - 1));
  assign last_q    = ((state == START) && (q == 2'd1)) ||
                     ((state == STOP)  && (q == 2'd2)) ||
                     ((is_byte || is_ack) && (q == 2'd3));
  assign finishing = (state == STOP) && (next == IDLE);

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:     if (handshake) next = BUS_WAIT;
      BUS_WAIT: if (scl_in && sda_in) next = START;
      START:    if (tick && last_q) next = ADDR;
      ADDR:     if (tick && last_q && bit_cnt == 3'd0) next = ACK_A;
      ACK_A:    if (tick && last_q) next = DATA0;
      DATA0:    if (tick && last_q && bit_cnt == 3'd0) next = ACK0;
      ACK0:     if (tick && last_q) next = has_arg_q ? DATA1 : STOP;
      DATA1:    if (tick && last_q && bit_cnt == 3'd0) next = ACK1;
      ACK1:     if (tick && last_q) next = STOP;
      STOP:     if (tick && last_q) next = IDLE;
      default:  next = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      qcnt      <= '0;
      q         <= '0;
      bit_cnt   <= '0;
      cmd_q     <= '0;
      arg_q     <= '0;
      has_arg_q <= 1'b0;
      nack_flag <= 1'b0;
      sda_oe    <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
    end else begin
      if (handshake) begin
        cmd_q     <= cmd_byte;
        arg_q     <= cmd_arg;
        has_arg_q <= cmd_has_arg;
      end
      if ((state == IDLE) || (state == BUS_WAIT)) qcnt <= '0;
      else if (!stall) qcnt <= tick ? '0 : qcnt + CW'(1);
      if (next != state) q <= '0;
      else if (tick)     q <= q + 2'd1;
      if ((next == ADDR || next == DATA0 || next == DATA1) && next != state)
        bit_cnt <= 3'd7;
      else if (is_byte && tick && last_q && bit_cnt != 3'd0)
        bit_cnt <= bit_cnt - 3'd1;
      if (finishing) nack_flag <= 1'b0;
      else if (is_ack && tick && q == 2'd2 && sda_in) nack_flag <= 1'b1;
      // SDA follows the phase decode one cycle late so it never moves on the same edge as SCL.
      sda_oe <= sda_drive;
      done   <= finishing;
      nack   <= finishing && nack_flag;
    end
  end

  always_comb begin
    cur_byte  = '0;
    scl_oe    = 1'b0;
    sda_drive = 1'b0;
    busy      = (state != IDLE);
    cmd_ready = (state == IDLE);
    unique case (state)
      ADDR:  cur_byte = {SLAVE_ADDR, 1'b0};
      DATA0: cur_byte = cmd_q;
      DATA1: cur_byte = arg_q;
      default: cur_byte = '0;
    endcase
    if (state == START) begin
      sda_drive = (q == 2'd1);
    end else if (is_byte) begin
      scl_oe    = (q == 2'd0);
      sda_drive = ~cur_byte[bit_cnt];
    end else if (is_ack) begin
      scl_oe    = (q == 2'd0);
    end else if (state == STOP) begin
      scl_oe    = (q == 2'd0);
      sda_drive = (q != 2'd2);
    end
  end

endmodule

// File: tb/tb_i2c_cmd_master.sv
// Directed bench for i2c_cmd_master with an open-drain bus, an ACK/NACK/stretching slave model
// and bus-level monitors for byte content, START/STOP and SDA movement while SCL is high.
module tb_i2c_cmd_master;

  localparam int unsigned DIV = 4;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_byte = '0;
  logic [7:0] cmd_arg = '0;
  logic       cmd_has_arg = 1'b0;
  logic       cmd_ready, scl_in, sda_in, scl_oe, sda_oe, busy, done, nack;

  logic       slave_sda = 1'b0;
  logic       bus_hold = 1'b0;
  logic       stretch_req = 1'b0;
  logic [7:0] ack_mask = 8'hFF;
  int         stretch_cnt = 0;
  logic       slave_scl;

  assign slave_scl = (stretch_cnt != 0);
  assign scl_in = ~(scl_oe | slave_scl);
  assign sda_in = ~(sda_oe | slave_sda | bus_hold);

  always #5 sysclk = ~sysclk;

  i2c_cmd_master #(.CLK_DIV(DIV), .SLAVE_ADDR(7'h41)) dut (
    .sysclk(sysclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_byte(cmd_byte), .cmd_arg(cmd_arg), .cmd_has_arg(cmd_has_arg),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .busy(busy), .done(done), .nack(nack)
  );

  // Slave model: decodes bytes on SCL rising edges, drives ACK per ack_mask, optional stretch.
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic [3:0] bitn = '0;
  logic [2:0] byte_idx = '0;
  logic [7:0] shreg = '0;
  logic [7:0] byte_log [0:7];
  int         starts = 0, stops = 0;

  always @(posedge sysclk) begin
    if (rst) begin
      prev_scl <= 1'b1; prev_sda <= 1'b1; bitn <= '0; byte_idx <= '0;
      slave_sda <= 1'b0; stretch_cnt <= 0;
    end else begin
      prev_scl <= scl_in;
      prev_sda <= sda_in;
      if (stretch_cnt != 0) stretch_cnt <= stretch_cnt - 1;
      if (prev_scl && scl_in && prev_sda && !sda_in) begin
        starts <= starts + 1; bitn <= '0; byte_idx <= '0;
      end else if (prev_scl && scl_in && !prev_sda && sda_in) begin
        stops <= stops + 1; bitn <= '0;
      end else if (!prev_scl && scl_in) begin
        if (bitn < 4'd8) shreg <= {shreg[6:0], sda_in};
        bitn <= bitn + 4'd1;
      end else if (prev_scl && !scl_in) begin
        if (bitn == 4'd8) begin
          byte_log[byte_idx] <= shreg;
          slave_sda <= ack_mask[byte_idx];
        end else if (bitn == 4'd9) begin
          slave_sda <= 1'b0; bitn <= '0; byte_idx <= byte_idx + 3'd1;
        end
        if (stretch_req && byte_idx == 3'd0 && bitn == 4'd4) stretch_cnt <= 500;
      end
    end
  end

  // Output monitor: done/nack pulses and SDA-output changes while SCL is released.
  int   done_cnt = 0, nack_cnt = 0, both_cnt = 0, glitch_cnt = 0;
  logic ps = 1'b0, pd = 1'b0;
  always @(posedge sysclk) begin
    ps <= scl_oe;
    pd <= sda_oe;
    if (done) done_cnt <= done_cnt + 1;
    if (nack) nack_cnt <= nack_cnt + 1;
    if (done && nack) both_cnt <= both_cnt + 1;
    if (!ps && !scl_oe && (pd != sda_oe)) glitch_cnt <= glitch_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  int d0, n0, b0, g0, s0, p0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    d0 = done_cnt; n0 = nack_cnt; b0 = both_cnt; g0 = glitch_cnt; s0 = starts; p0 = stops;
  endtask

  task automatic issue(input logic [7:0] b, input logic [7:0] a, input logic h);
    @(negedge sysclk);
    cmd_byte = b; cmd_arg = a; cmd_has_arg = h; cmd_valid = 1'b1;
    @(posedge sysclk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    while (cyc < 3000 && !ok) begin
      @(posedge sysclk); cyc++;
      @(negedge sysclk); ok = done;
    end
  endtask

  task automatic end_tx(input string t);
    chk({t, "_idle_busy"}, 32'(busy), 0);
    chk({t, "_idle_ready"}, 32'(cmd_ready), 1);
    chk({t, "_idle_oe"}, 32'({scl_oe, sda_oe}), 0);
    @(posedge sysclk); #1;
    chk({t, "_done_1cyc"}, 32'(done), 0);
  endtask

  int cyc;
  bit ok;
  int ext;

  initial begin
    // reset state
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_oe", 32'({scl_oe, sda_oe}), 0);
    chk("rst_pulses", 32'({done, nack}), 0);
    rst = 1'b0;
    repeat (2) @(negedge sysclk);

    // 0x02 without argument, all ACKed
    snap();
    issue(8'h02, 8'h00, 1'b0);
    wait_done(cyc, ok);
    chk("t1_done_seen", 32'(ok), 1);
    chk("t1_cycles", 32'(cyc), 309);
    chk("t1_nack_at_done", 32'(nack), 0);
    end_tx("t1");
    chk("t1_nbytes", 32'(byte_idx), 2);
    chk("t1_addr", 32'(byte_log[0]), 32'h82);
    chk("t1_cmd", 32'(byte_log[1]), 32'h02);
    chk("t1_done_cnt", 32'(done_cnt - d0), 1);
    chk("t1_nack_cnt", 32'(nack_cnt - n0), 0);
    chk("t1_start_stop", 32'({starts - s0, stops - p0}), {32'd1, 32'd1});
    chk("t1_sda_moves_scl_high", 32'(glitch_cnt - g0), 2);

    // 0x10 with argument 0x80
    snap();
    issue(8'h10, 8'h80, 1'b1);
    wait_done(cyc, ok);
    chk("t2_done_seen", 32'(ok), 1);
    chk("t2_cycles", 32'(cyc), 453);
    chk("t2_nack_at_done", 32'(nack), 0);
    end_tx("t2");
    chk("t2_nbytes", 32'(byte_idx), 3);
    chk("t2_bytes", {8'h00, byte_log[0], byte_log[1], byte_log[2]}, 32'h00821080);
    chk("t2_stops", 32'(stops - p0), 1);

    // address NACKed; cmd_valid held while busy must be ignored
    snap();
    ack_mask = 8'hFE;
    issue(8'h0A, 8'h00, 1'b0);
    cmd_valid = 1'b1; cmd_byte = 8'h55;
    repeat (40) @(negedge sysclk);
    chk("t3_ready_busy", 32'({cmd_ready, busy}), 32'b01);
    cmd_valid = 1'b0;
    wait_done(cyc, ok);
    chk("t3_done_seen", 32'(ok), 1);
    chk("t3_nack_with_done", 32'(nack), 1);
    end_tx("t3");
    chk("t3_nbytes", 32'(byte_idx), 2);
    chk("t3_bytes", {16'h0, byte_log[0], byte_log[1]}, 32'h820A);
    chk("t3_coincident", 32'({both_cnt - b0, nack_cnt - n0, done_cnt - d0}), {32'd1, 32'd1, 32'd1});
    ack_mask = 8'hFF;

    // 500-cycle stretch during ADDR bit 3
    snap();
    stretch_req = 1'b1;
    issue(8'h02, 8'h00, 1'b0);
    wait_done(cyc, ok);
    stretch_req = 1'b0;
    chk("t4_done_seen", 32'(ok), 1);
    ext = cyc - 309;
    chk("t4_extension", 32'((ext >= 490) && (ext <= 505)), 1);
    end_tx("t4");
    chk("t4_bytes", {16'h0, byte_log[0], byte_log[1]}, 32'h8202);
    chk("t4_sda_moves_scl_high", 32'(glitch_cnt - g0), 2);
    chk("t4_nack_cnt", 32'(nack_cnt - n0), 0);

    // SDA held low by another device: wait in BUS_WAIT
    snap();
    bus_hold = 1'b1;
    repeat (5) @(negedge sysclk);
    issue(8'h01, 8'h00, 1'b0);
    repeat (50) @(negedge sysclk);
    chk("t5_wait_busy_ready", 32'({busy, cmd_ready}), 32'b10);
    chk("t5_wait_oe", 32'({scl_oe, sda_oe}), 0);
    bus_hold = 1'b0;
    wait_done(cyc, ok);
    chk("t5_done_seen", 32'(ok), 1);
    chk("t5_cycles", 32'(cyc), 309);
    end_tx("t5");
    chk("t5_bytes", {16'h0, byte_log[0], byte_log[1]}, 32'h8201);

    // asynchronous reset during DATA0 bit 5
    snap();
    issue(8'h0B, 8'h00, 1'b0);
    cyc = 0;
    while (cyc < 2000 && !(byte_idx == 3'd1 && bitn == 4'd2 && !scl_in)) begin
      @(negedge sysclk); cyc++;
    end
    chk("t6_reached_bit5", 32'(cyc < 2000), 1);
    chk("t6_pre_busy_scl", 32'({busy, scl_oe}), 32'b11);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_oe", 32'({scl_oe, sda_oe}), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    repeat (2) @(negedge sysclk);
    chk("t6_no_stop_no_done", 32'({stops - p0, done_cnt - d0}), 0);

    // next command after the reset completes normally
    snap();
    issue(8'h01, 8'h00, 1'b0);
    wait_done(cyc, ok);
    chk("t7_done_seen", 32'(ok), 1);
    chk("t7_cycles", 32'(cyc), 309);
    end_tx("t7");
    chk("t7_bytes", {16'h0, byte_log[0], byte_log[1]}, 32'h8201);
    chk("t7_done_nack", 32'({done_cnt - d0, nack_cnt - n0}), {32'd1, 32'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
